tlu_event_scheduler: RTL

- Sequences trigger-event and heartbeat records into the TLU master's 32-bit readout FIFO, one word per cycle.
- Sits between the CLK40 trigger datapath (GEN_TRIG_PULSE, TRIG_ID, TIME_STAMP, skip/timeout counters) and the FIFO write port.
- Arbitrates two requesters, trigger (priority) and periodic heartbeat, for the single FIFO write interface.
- Records are written atomically, never interleaved, and lost triggers are counted.

---
 rtl/tlu_event_pkg.sv | 27 ++
 rtl/tlu_hb_timer.sv | 42 ++++
 rtl/tlu_event_scheduler.sv | 126 ++++++++++++
 3 files changed

// File: rtl/tlu_event_pkg.sv
// Shared types and constants for the TLU event scheduler.
// Build option TLU_EVENT_TS64_EN adds a fourth record word carrying TIME_STAMP[63:56].
package tlu_event_pkg;

   localparam logic [3:0] TRIG_HDR = 4'b1001;
   localparam logic [3:0] HB_HDR   = 4'b1010;
   localparam logic [3:0] TS_LO    = 4'b0001;
   localparam logic [3:0] TS_HI    = 4'b0010;
   localparam logic [3:0] TS_TOP   = 4'b0011;

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_W0   = 3'd1,
      ST_W1   = 3'd2,
      ST_W2   = 3'd3,
      ST_W3   = 3'd4
   } tlu_state_e;

`ifdef TLU_EVENT_TS64_EN
   localparam int WORDS_PER_REC = 4;
   localparam int TS_USED_W     = 64;
`else
   localparam int WORDS_PER_REC = 3;
   localparam int TS_USED_W     = 56;
`endif

endpackage

// File: rtl/tlu_hb_timer.sv
// Heartbeat period counter with a sticky request flag cleared when the
// scheduler grants the heartbeat record.
module tlu_hb_timer
#(
   parameter int HB_CNT_W = 16
)
(
   input  logic                CLK40,
   input  logic                RST_N,
   input  logic                ENABLE,
   input  logic [HB_CNT_W-1:0] HB_PERIOD,
   input  logic                hb_clr,
   output logic                hb_pend
);

   logic [HB_CNT_W-1:0] hb_cnt;
   logic                hb_run;
   logic                hb_hit;

   assign hb_run = ENABLE && (HB_PERIOD != '0);
   // >= keeps the counter from running off to wrap-around if HB_PERIOD shrinks mid-count
   assign hb_hit = hb_run && (hb_cnt >= (HB_PERIOD - HB_CNT_W'(1)));

   always_ff @(posedge CLK40 or negedge RST_N) begin
      if (!RST_N) begin
         hb_cnt  <= '0;
         hb_pend <= 1'b0;
      end else begin
         if (!hb_run || hb_hit) begin
            hb_cnt <= '0;
         end else begin
            hb_cnt <= hb_cnt + HB_CNT_W'(1);
         end
         if (hb_hit) begin
            hb_pend <= 1'b1;
         end else if (hb_clr) begin
            hb_pend <= 1'b0;
         end
      end
   end

endmodule

// File: rtl/tlu_event_scheduler.sv
// Serialises trigger and heartbeat records into the TLU readout FIFO, one word per cycle.
// Build option TLU_EVENT_TS64_EN selects 4-word records (adds TS_TOP word).
module tlu_event_scheduler
   import tlu_event_pkg::*;
#(
   parameter int HB_CNT_W   = 16,
   parameter int LOST_CNT_W = 8
)
(
   input  logic                  CLK40,
   input  logic                  RST_N,
   input  logic                  ENABLE,
   input  logic                  TRIG,
   input  logic [31:0]           TRIG_ID,
   input  logic [63:0]           TIME_STAMP,
   input  logic [7:0]            SKIP_CNT,
   input  logic [7:0]            TIMEOUT_CNT,
   input  logic [HB_CNT_W-1:0]   HB_PERIOD,
   input  logic                  FIFO_FULL,
   output logic                  FIFO_WRITE,
   output logic [31:0]           FIFO_DATA,
   output logic [LOST_CNT_W-1:0] LOST_CNT,
   output logic                  BUSY,
   output tlu_state_e            DBG_STATE
);

   tlu_state_e           state;
   logic                 trig_pend;
   logic [27:0]          pend_id;
   logic [TS_USED_W-1:0] pend_ts;
   logic [31:0]          rec_hdr;
   logic [TS_USED_W-1:0] rec_ts;
   logic                 hb_pend;
   logic                 grant_trig;
   logic                 grant_hb;
   logic                 unused_bits;

`ifdef TLU_EVENT_TS64_EN
   assign unused_bits = ^TRIG_ID[31:28];
`else
   assign unused_bits = ^{TRIG_ID[31:28], TIME_STAMP[63:56]};
`endif

   // Write handshake: FIFO_WRITE already includes !FIFO_FULL, so any cycle with
   // FIFO_WRITE=1 transfers FIFO_DATA; while full, state and FIFO_DATA hold.
   assign FIFO_WRITE = (state != ST_IDLE) && !FIFO_FULL;
   assign grant_trig = (state == ST_IDLE) && trig_pend;
   assign grant_hb   = (state == ST_IDLE) && !trig_pend && hb_pend;
   assign BUSY       = trig_pend | hb_pend | (state != ST_IDLE);
   assign DBG_STATE  = state;

   tlu_hb_timer #(
      .HB_CNT_W (HB_CNT_W)
   ) u_hb_timer (
      .CLK40     (CLK40),
      .RST_N     (RST_N),
      .ENABLE    (ENABLE),
      .HB_PERIOD (HB_PERIOD),
      .hb_clr    (grant_hb),
      .hb_pend   (hb_pend)
   );

   // One-deep trigger buffer; a slot freed by this cycle's grant can be refilled at once
   always_ff @(posedge CLK40 or negedge RST_N) begin
      if (!RST_N) begin
         trig_pend <= 1'b0;
         pend_id   <= '0;
         pend_ts   <= '0;
         LOST_CNT  <= '0;
      end else begin
         if (grant_trig) begin
            trig_pend <= 1'b0;
         end
         if (ENABLE && TRIG) begin
            if (!trig_pend || grant_trig) begin
               trig_pend <= 1'b1;
               pend_id   <= TRIG_ID[27:0];
               pend_ts   <= TIME_STAMP[TS_USED_W-1:0];
            end else if (LOST_CNT != '1) begin
               LOST_CNT <= LOST_CNT + LOST_CNT_W'(1);
            end
         end
      end
   end

   always_ff @(posedge CLK40 or negedge RST_N) begin
      if (!RST_N) begin
         state   <= ST_IDLE;
         rec_hdr <= '0;
         rec_ts  <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (grant_trig) begin
                  rec_hdr <= {TRIG_HDR, pend_id};
                  rec_ts  <= pend_ts;
                  state   <= ST_W0;
               end else if (grant_hb) begin
                  rec_hdr <= {HB_HDR, 12'b0, TIMEOUT_CNT, SKIP_CNT};
                  rec_ts  <= TIME_STAMP[TS_USED_W-1:0];
                  state   <= ST_W0;
               end
            end
            ST_W0: if (FIFO_WRITE) state <= ST_W1;
            ST_W1: if (FIFO_WRITE) state <= ST_W2;
            ST_W2: if (FIFO_WRITE) state <= (WORDS_PER_REC > 3) ? ST_W3 : ST_IDLE;
            ST_W3: if (FIFO_WRITE) state <= ST_IDLE;
            default: state <= ST_IDLE;
         endcase
      end
   end

   always_comb begin
      FIFO_DATA = '0;
      case (state)
         ST_W0: FIFO_DATA = rec_hdr;
         ST_W1: FIFO_DATA = {TS_LO, rec_ts[27:0]};
         ST_W2: FIFO_DATA = {TS_HI, rec_ts[55:28]};
`ifdef TLU_EVENT_TS64_EN
         ST_W3: FIFO_DATA = {TS_TOP, 20'b0, rec_ts[63:56]};
`endif
         default: FIFO_DATA = '0;
      endcase
   end

endmodule
